keymap_reader: RTL and testbench

- Read-side counterpart of the Set-mode key-remap writer. The writer fills the 7-entry remap RAM with `RAM[one-hot key] = one-hot note`.
- This block debounces the raw `note_key` switches and looks up the remapped note in that RAM. It delivers a clean one-hot note plus a new-press pulse to the Free/Play/Study mode logic.
- It also runs an integrity scan of the table. If the table is not a valid permutation, translation falls back to identity.

---
 rtl/keymap_reader_pkg.sv | 19 +
 rtl/keymap_reader_stable_sampler.sv | 48 ++++
 rtl/keymap_reader.sv | 217 +++++++++++++++++++++
 tb/tb_keymap_reader.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keymap_reader_pkg.sv
// Shared constants and state codes for the key-remap read path.
package keymap_reader_pkg;

  // Width of the note switch bank, remap RAM address and remap RAM data.
  localparam int NOTE_KEY_BITS = 7;

  // 20 ms of stable input at 100 MHz.
  localparam int DEBOUNCE_20MS = 2000000;

  typedef enum logic [2:0] {
    KEYMAP_IDLE       = 3'd0,
    KEYMAP_SCAN_RD    = 3'd1,
    KEYMAP_SCAN_CHK   = 3'd2,
    KEYMAP_WAIT_PRESS = 3'd3,
    KEYMAP_LOOKUP     = 3'd4,
    KEYMAP_HOLD       = 3'd5
  } keymap_state_e;

endpackage

// File: rtl/keymap_reader_stable_sampler.sv
// Run-length debouncer: counts consecutive cycles on which the input is
// nonzero and unchanged. stable_o rises on the cycle the run reaches
// DEBOUNCE_CYC and stays up while the run continues. clr_i restarts the run.
module stable_sampler #(
  parameter int W            = 7,
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic [W-1:0] data_i,
  output logic         stable_o,
  output logic [W-1:0] value_o
);

  localparam int            CW   = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYC);

  logic [W-1:0]  prev_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // Run length including the current sample; saturates at the threshold.
  always_comb begin
    cnt_d = '0;
    if (data_i != '0) begin
      if (data_i == prev_q) cnt_d = (cnt_q == CMAX) ? CMAX : cnt_q + CW'(1);
      else                  cnt_d = CW'(1);
    end
  end

  assign stable_o = !clr_i && (cnt_d == CMAX);
  assign value_o  = data_i;

  // Remember the previous sample and the run length so far.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_q <= '0;
      cnt_q  <= '0;
    end else if (clr_i) begin
      prev_q <= '0;
      cnt_q  <= '0;
    end else begin
      prev_q <= data_i;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/keymap_reader.sv
// Debounces the note switches, translates the pressed key through the remap
// RAM and checks that the RAM holds a one-hot permutation. A table that fails
// the check makes translation fall back to identity.
module keymap_reader
  import keymap_reader_pkg::*;
#(
  parameter int KEY_W        = NOTE_KEY_BITS,
  parameter int DEBOUNCE_CYC = DEBOUNCE_20MS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [KEY_W-1:0] note_key,
  input  logic             scan_req,
  output logic [KEY_W-1:0] ram_addr,
  output logic             ram_re,
  input  logic [KEY_W-1:0] ram_rdata,
  output logic [KEY_W-1:0] note_out,
  output logic             note_valid,
  output logic [KEY_W-1:0] note_held,
  output logic             bad_key,
  output logic             table_ok,
  output logic             scan_busy
);

  localparam int             IW       = (KEY_W > 1) ? $clog2(KEY_W) : 1;
  localparam logic [IW-1:0]  LAST_IDX = IW'(KEY_W - 1);

  function automatic logic is_onehot(input logic [KEY_W-1:0] x);
    return (x != '0) && ((x & (x - KEY_W'(1))) == '0);
  endfunction

  keymap_state_e    state_q, state_d;
  logic [IW-1:0]    idx_q;
  logic [KEY_W-1:0] seen_q;
  logic             fail_q;
  logic [KEY_W-1:0] key_q;
  logic             lk_rd_q;
  logic [KEY_W-1:0] note_out_q;
  logic             note_valid_q;
  logic             bad_key_q;
  logic             table_ok_q;
  logic             pending_q, pending_d;

  logic             press_stable;
  logic [KEY_W-1:0] press_val;
  logic             rel_miss, rel_stable, rel_val, rel_acc;

  logic             scanning, scan_start;
  logic             entry_bad, fail_nx;
  logic [KEY_W-1:0] seen_nx;
  logic             lk_done;
  logic [KEY_W-1:0] lk_res;

  // Press debounce only runs while waiting for a press, so every press
  // debounce starts from zero.
  stable_sampler #(.W(KEY_W), .DEBOUNCE_CYC(DEBOUNCE_CYC)) u_press (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (state_q != KEYMAP_WAIT_PRESS),
    .data_i   (note_key),
    .stable_o (press_stable),
    .value_o  (press_val)
  );

  // Release debounce counts cycles on which the switches differ from the
  // latched key; a cycle matching the latched key breaks the run.
  assign rel_miss = (note_key != key_q);

  stable_sampler #(.W(1), .DEBOUNCE_CYC(DEBOUNCE_CYC)) u_release (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (state_q != KEYMAP_HOLD),
    .data_i   (rel_miss),
    .stable_o (rel_stable),
    .value_o  (rel_val)
  );

  assign rel_acc  = rel_stable & rel_val;
  assign scanning = (state_q == KEYMAP_SCAN_RD) || (state_q == KEYMAP_SCAN_CHK);

  // Table entry check and lookup result selection.
  assign entry_bad = !is_onehot(ram_rdata) || ((ram_rdata & seen_q) != '0);
  assign seen_nx   = seen_q | ram_rdata;
  assign fail_nx   = fail_q | entry_bad;
  assign lk_done   = (state_q == KEYMAP_LOOKUP) && (!table_ok_q || lk_rd_q);
  assign lk_res    = table_ok_q ? ram_rdata : key_q;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= KEYMAP_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; dropping en always returns to IDLE.
  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = KEYMAP_IDLE;
    end else begin
      case (state_q)
        KEYMAP_IDLE:     state_d = pending_q ? KEYMAP_SCAN_RD : KEYMAP_WAIT_PRESS;
        KEYMAP_SCAN_RD:  state_d = KEYMAP_SCAN_CHK;
        KEYMAP_SCAN_CHK: state_d = (idx_q == LAST_IDX) ? KEYMAP_WAIT_PRESS : KEYMAP_SCAN_RD;
        KEYMAP_WAIT_PRESS: begin
          if (pending_q && (note_key == '0)) state_d = KEYMAP_SCAN_RD;
          else if (press_stable)             state_d = is_onehot(press_val) ? KEYMAP_LOOKUP : KEYMAP_HOLD;
        end
        KEYMAP_LOOKUP:   if (lk_done) state_d = KEYMAP_HOLD;
        KEYMAP_HOLD:     if (rel_acc) state_d = KEYMAP_WAIT_PRESS;
        default:         state_d = KEYMAP_IDLE;
      endcase
    end
  end

  assign scan_start = (state_d == KEYMAP_SCAN_RD) &&
                      ((state_q == KEYMAP_IDLE) || (state_q == KEYMAP_WAIT_PRESS));

  // A request landing in the same cycle a scan starts is kept, so it earns
  // its own follow-up scan.
  always_comb begin
    pending_d = pending_q;
    if (scan_start)        pending_d = 1'b0;
    if (!en && scanning)   pending_d = 1'b1;
    if (scan_req)          pending_d = 1'b1;
  end

  // Datapath: scan accumulation, key latch, lookup result and pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q        <= '0;
      seen_q       <= '0;
      fail_q       <= 1'b0;
      key_q        <= '0;
      lk_rd_q      <= 1'b0;
      note_out_q   <= '0;
      note_valid_q <= 1'b0;
      bad_key_q    <= 1'b0;
      table_ok_q   <= 1'b0;
      pending_q    <= 1'b0;
    end else begin
      note_valid_q <= 1'b0;
      bad_key_q    <= 1'b0;
      pending_q    <= pending_d;
      if (!en) begin
        lk_rd_q <= 1'b0;
        if (scanning) table_ok_q <= 1'b0;
      end else begin
        if (scan_start) begin
          idx_q  <= '0;
          seen_q <= '0;
          fail_q <= 1'b0;
        end
        case (state_q)
          KEYMAP_WAIT_PRESS: begin
            if (press_stable) begin
              key_q <= press_val;
              if (!is_onehot(press_val)) begin
                bad_key_q  <= 1'b1;
                note_out_q <= '0;
              end
            end
          end
          KEYMAP_SCAN_CHK: begin
            seen_q <= seen_nx;
            fail_q <= fail_nx;
            if (idx_q == LAST_IDX) table_ok_q <= !fail_nx && (seen_nx == '1);
            else                   idx_q      <= idx_q + IW'(1);
          end
          KEYMAP_LOOKUP: begin
            if (lk_done) begin
              lk_rd_q <= 1'b0;
              if (is_onehot(lk_res)) begin
                note_out_q   <= lk_res;
                note_valid_q <= 1'b1;
              end else begin
                bad_key_q  <= 1'b1;
                note_out_q <= '0;
              end
            end else begin
              lk_rd_q <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Outputs decoded from state; RAM is only addressed in SCAN_RD and the
  // first LOOKUP cycle of a table-backed lookup.
  always_comb begin
    ram_addr = '0;
    ram_re   = 1'b0;
    case (state_q)
      KEYMAP_SCAN_RD: begin
        ram_addr = KEY_W'(1) << idx_q;
        ram_re   = 1'b1;
      end
      KEYMAP_LOOKUP: begin
        if (table_ok_q && !lk_rd_q) begin
          ram_addr = key_q;
          ram_re   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign scan_busy  = scanning;
  assign note_held  = (state_q == KEYMAP_HOLD) ? note_out_q : '0;
  assign note_out   = note_out_q;
  assign note_valid = note_valid_q;
  assign bad_key    = bad_key_q;
  assign table_ok   = table_ok_q;

endmodule

// File: tb/tb_keymap_reader.sv
// Self-checking bench for keymap_reader: directed scenarios with hand-derived
// expectations, a lookup table of press vectors, and a randomized phase, all
// shadowed every cycle by a behavioural model of the read path.
module tb_keymap_reader;

  localparam int KW       = 7;
  localparam int DEB      = 4;
  localparam int SCAN_CYC = 2 * KW;

  logic          clk = 1'b0;
  logic          rst_n, en, scan_req;
  logic [KW-1:0] note_key, ram_addr, note_out, note_held;
  logic [KW-1:0] ram_rdata = '0;
  logic          ram_re, note_valid, bad_key, table_ok, scan_busy;

  always #5 clk = ~clk;

  keymap_reader #(.KEY_W(KW), .DEBOUNCE_CYC(DEB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .note_key   (note_key),
    .scan_req   (scan_req),
    .ram_addr   (ram_addr),
    .ram_re     (ram_re),
    .ram_rdata  (ram_rdata),
    .note_out   (note_out),
    .note_valid (note_valid),
    .note_held  (note_held),
    .bad_key    (bad_key),
    .table_ok   (table_ok),
    .scan_busy  (scan_busy)
  );

  // Remap RAM: registered read, data valid the cycle after ram_re.
  logic [KW-1:0] mem [KW];

  function automatic logic [KW-1:0] rd_mem(input logic [KW-1:0] a);
    for (int i = 0; i < KW; i++) if (a == (7'd1 << i)) return mem[i];
    return '0;
  endfunction

  always @(posedge clk) if (ram_re) ram_rdata <= rd_mem(ram_addr);

  // ---------------- behavioural model ----------------
  typedef enum int {M_IDLE, M_SCAN, M_WAIT, M_LOOK, M_HOLD} mphase_t;
  mphase_t       m_ph;
  int            m_scan_left, m_look_left, m_run, m_rel;
  logic [KW-1:0] m_prevk, m_lkey, m_nout;
  logic          m_tok, m_pend, m_valid, m_bad;

  int nvec = 0, nerr = 0, re_cnt = 0, nv_cnt = 0;

  function automatic logic onehot(input logic [KW-1:0] x);
    return $countones(x) == 1;
  endfunction

  // Valid table: every note bit is produced by exactly one entry.
  function automatic logic is_perm();
    for (int j = 0; j < KW; j++) begin
      int n;
      n = 0;
      for (int i = 0; i < KW; i++) if (mem[i] == (7'd1 << j)) n++;
      if (n != 1) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic int idx_of(input logic [KW-1:0] x);
    for (int i = 0; i < KW; i++) if (x[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_ph = M_IDLE; m_scan_left = 0; m_look_left = 0; m_run = 0; m_rel = 0;
    m_prevk = '0; m_lkey = '0; m_nout = '0;
    m_tok = 1'b0; m_pend = 1'b0; m_valid = 1'b0; m_bad = 1'b0;
  endtask

  task automatic enter_wait();
    m_ph = M_WAIT; m_run = 0; m_prevk = '0;
  endtask

  task automatic start_scan();
    m_ph = M_SCAN; m_scan_left = SCAN_CYC; m_pend = 1'b0;
  endtask

  task automatic model_step(input logic r, input logic e, input logic [KW-1:0] k, input logic req);
    logic [KW-1:0] res;
    if (!r) begin model_reset(); return; end
    m_valid = 1'b0; m_bad = 1'b0;
    if (!e) begin
      if (m_ph == M_SCAN) begin m_tok = 1'b0; m_pend = 1'b1; end
      m_ph = M_IDLE;
    end else begin
      case (m_ph)
        M_IDLE: if (m_pend) start_scan(); else enter_wait();
        M_SCAN: begin
          m_scan_left--;
          if (m_scan_left == 0) begin m_tok = is_perm(); enter_wait(); end
        end
        M_WAIT: begin
          if (m_pend && k == '0) start_scan();
          else begin
            if (k != '0 && k == m_prevk) m_run++;
            else m_run = (k != '0) ? 1 : 0;
            m_prevk = k;
            if (m_run >= DEB) begin
              m_lkey = k;
              if (onehot(k)) begin m_ph = M_LOOK; m_look_left = m_tok ? 2 : 1; end
              else begin m_bad = 1'b1; m_nout = '0; m_ph = M_HOLD; m_rel = 0; end
            end
          end
        end
        M_LOOK: begin
          m_look_left--;
          if (m_look_left == 0) begin
            res = m_tok ? mem[idx_of(m_lkey)] : m_lkey;
            if (onehot(res)) begin m_nout = res; m_valid = 1'b1; end
            else begin m_nout = '0; m_bad = 1'b1; end
            m_ph = M_HOLD; m_rel = 0;
          end
        end
        M_HOLD: begin
          if (k != m_lkey) m_rel++; else m_rel = 0;
          if (m_rel >= DEB) enter_wait();
        end
        default: m_ph = M_IDLE;
      endcase
    end
    if (req) m_pend = 1'b1;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    nvec++;
    if (act !== exp_v) begin
      nerr++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp_v);
    end
  endtask

  task automatic compare_model();
    logic          exp_re;
    logic [KW-1:0] exp_addr, exp_held;
    exp_re   = 1'b0;
    exp_addr = '0;
    if (m_ph == M_SCAN && ((SCAN_CYC - m_scan_left) % 2 == 0)) begin
      exp_re = 1'b1; exp_addr = 7'd1 << ((SCAN_CYC - m_scan_left) / 2);
    end
    if (m_ph == M_LOOK && m_look_left == 2) begin exp_re = 1'b1; exp_addr = m_lkey; end
    exp_held = (m_ph == M_HOLD) ? m_nout : '0;
    check("m_scan_busy", scan_busy, (m_ph == M_SCAN));
    check("m_ram_re", ram_re, exp_re);
    if (exp_re) check("m_ram_addr", ram_addr, exp_addr);
    check("m_table_ok", table_ok, m_tok);
    check("m_note_out", note_out, m_nout);
    check("m_note_valid", note_valid, m_valid);
    check("m_bad_key", bad_key, m_bad);
    check("m_note_held", note_held, exp_held);
  endtask

  task automatic tick();
    logic r, e, q;
    logic [KW-1:0] k;
    r = rst_n; e = en; q = scan_req; k = note_key;
    @(posedge clk);
    model_step(r, e, k, q);
    #1;
    compare_model();
    if (ram_re) re_cnt++;
    if (note_valid) nv_cnt++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Waits (bounded) for a scan to begin, then measures its length.
  task automatic run_scan(input string nm, input logic exp_ok);
    int n, guard;
    n = 0; guard = 0;
    while (!scan_busy && guard < 40) begin tick(); guard++; end
    while (scan_busy && n < 40) begin n++; tick(); end
    check({nm, "_len"}, n, SCAN_CYC);
    check({nm, "_ok"}, table_ok, exp_ok);
  endtask

  task automatic request_scan();
    scan_req = 1'b1; tick(); scan_req = 1'b0;
  endtask

  task automatic set_identity();
    for (int i = 0; i < KW; i++) mem[i] = 7'd1 << i;
  endtask

  typedef struct {
    logic [KW-1:0] key;
    logic [KW-1:0] exp_note;
    logic          exp_bad;
    int            exp_lat;
  } press_vec_t;

  initial begin
    press_vec_t vt [6];
    int i, nv0, re0, busy_seen;

    // Remapped table: key0->bit6, key6->bit0, rest identity.
    vt[0] = '{7'b0000001, 7'b1000000, 1'b0, DEB + 2};
    vt[1] = '{7'b1000000, 7'b0000001, 1'b0, DEB + 2};
    vt[2] = '{7'b0000100, 7'b0000100, 1'b0, DEB + 2};
    vt[3] = '{7'b0000011, 7'b0000000, 1'b1, DEB};
    vt[4] = '{7'b0010000, 7'b0010000, 1'b0, DEB + 2};
    vt[5] = '{7'b1100000, 7'b0000000, 1'b1, DEB};

    rst_n = 1'b0; en = 1'b0; scan_req = 1'b0; note_key = '0;
    set_identity();
    model_reset();
    ticks(2);
    check("rst_note_out", note_out, 0);
    check("rst_table_ok", table_ok, 0);
    check("rst_scan_busy", scan_busy, 0);
    check("rst_ram_re", ram_re, 0);

    // 1: identity table, press with exact latency, then release.
    rst_n = 1'b1; en = 1'b1;
    request_scan();
    run_scan("t1_scan", 1'b1);
    note_key = 7'b0000100;
    ticks(DEB);
    check("t1_valid_at_accept", note_valid, 0);
    check("t1_lookup_re", ram_re, 1);
    tick();
    check("t1_valid_lat1", note_valid, 0);
    tick();
    check("t1_valid_lat2", note_valid, 1);
    check("t1_note_out", note_out, 7'b0000100);
    check("t1_note_held", note_held, 7'b0000100);
    note_key = '0;
    ticks(DEB - 1);
    check("t1_held_before_rel", note_held, 7'b0000100);
    tick();
    check("t1_held_after_rel", note_held, 0);
    check("t1_note_out_kept", note_out, 7'b0000100);

    // 2: remapped table, table-driven presses.
    mem[0] = 7'b1000000; mem[6] = 7'b0000001;
    request_scan();
    run_scan("t2_scan", 1'b1);
    for (int v = 0; v < 6; v++) begin
      note_key = vt[v].key;
      i = 0;
      while (!(note_valid || bad_key) && i < 12) begin tick(); i++; end
      check("t2_latency", i, vt[v].exp_lat);
      check("t2_note_valid", note_valid, !vt[v].exp_bad);
      check("t2_bad_key", bad_key, vt[v].exp_bad);
      check("t2_note_out", note_out, vt[v].exp_note);
      tick();
      check("t2_note_held", note_held, vt[v].exp_bad ? 7'd0 : vt[v].exp_note);
      note_key = '0;
      ticks(DEB);
      check("t2_released", note_held, 0);
      check("t2_out_kept", note_out, vt[v].exp_note);
      ticks(2);
    end

    // 3: duplicate entries -> identity fallback, no RAM reads on lookup.
    mem[0] = 7'b0000001; mem[6] = 7'b1000000; mem[2] = 7'b0000010;
    request_scan();
    run_scan("t3_scan", 1'b0);
    re0 = re_cnt;
    note_key = 7'b0000001;
    i = 0;
    while (!note_valid && i < 12) begin tick(); i++; end
    check("t3_latency", i, DEB + 1);
    check("t3_note_out", note_out, 7'b0000001);
    check("t3_no_ram_re", re_cnt - re0, 0);
    note_key = '0;
    ticks(DEB + 2);

    // 4: bouncing key never debounces.
    nv0 = nv_cnt;
    for (int t = 0; t < 24; t++) begin
      note_key = ((t / 2) % 2 == 0) ? 7'b0000100 : 7'b0000000;
      tick();
    end
    note_key = '0;
    ticks(DEB + 2);
    check("t4_bounce_no_valid", nv_cnt - nv0, 0);

    // 5: abort a scan with en, then a full rescan.
    set_identity();
    request_scan();
    run_scan("t5_first", 1'b1);
    request_scan();
    i = 0;
    while (!scan_busy && i < 10) begin tick(); i++; end
    ticks(5);
    check("t5_busy_mid", scan_busy, 1);
    en = 1'b0;
    tick();
    check("t5_abort_busy", scan_busy, 0);
    check("t5_abort_ok", table_ok, 0);
    ticks(2);
    en = 1'b1;
    run_scan("t5_rescan", 1'b1);

    // 6: scan request while held waits for the release debounce.
    note_key = 7'b0001000;
    i = 0;
    while (!note_valid && i < 12) begin tick(); i++; end
    check("t6_pressed", note_out, 7'b0001000);
    request_scan();
    busy_seen = 0;
    for (int t = 0; t < 10; t++) begin tick(); if (scan_busy) busy_seen++; end
    check("t6_no_scan_while_held", busy_seen, 0);
    note_key = '0;
    nv0 = nv_cnt;
    run_scan("t6_scan", 1'b1);
    check("t6_no_valid_in_scan", nv_cnt - nv0, 0);

    // Randomized phase against the model.
    for (int t = 0; t < 1500; t++) begin
      en       = ($urandom_range(0, 39) != 0);
      scan_req = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0:       note_key = '0;
          3:       note_key = 7'($urandom);
          default: note_key = 7'd1 << $urandom_range(0, 6);
        endcase
      end
      if ($urandom_range(0, 99) == 0 && m_ph != M_SCAN && m_ph != M_LOOK) begin
        set_identity();
        if ($urandom_range(0, 2) != 0) begin
          for (int a = KW - 1; a > 0; a--) begin
            int b;
            logic [KW-1:0] tmp;
            b = $urandom_range(0, a);
            tmp = mem[a]; mem[a] = mem[b]; mem[b] = tmp;
          end
        end else begin
          mem[$urandom_range(0, 6)] = 7'($urandom);
        end
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
